arc4_encrypt: RTL and testbench

- ARC4 encryptor: the writer-side counterpart of the ARC4 decryption path.
- Reads a length-prefixed plaintext message from pt memory and generates the keystream from an already-initialised S memory (post-KSA).
- Writes a length-prefixed ciphertext into ct memory, in the same format the decryption path consumes.
- Started and monitored by a controller through the team's rdy/en handshake; sits beside init/ksa/prga under the task top level.

---
 rtl/arc4_encrypt.sv | 131 +++++++++++++
 tb/tb_arc4_encrypt.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, runs PRGA over an already
// keyed S memory and writes a length-prefixed ciphertext.
module arc4_encrypt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, WAIT_LEN, WR_LEN, INC_I, WAIT_SI, CALC_J,
    WAIT_SJ, WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_CT
  } state_t;

  state_t     state_reg;
  logic [7:0] i_reg, j_reg, si_reg, sj_reg, len_reg;
  logic [8:0] k_reg;

  // Outputs are registered: each branch loads the values the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rdy       <= 1'b1;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      pt_addr   <= 8'd0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      ct_wren   <= 1'b0;
      i_reg     <= 8'd0;
      j_reg     <= 8'd0;
      si_reg    <= 8'd0;
      sj_reg    <= 8'd0;
      len_reg   <= 8'd0;
      k_reg     <= 9'd0;
    end else begin
      s_wren  <= 1'b0;
      ct_wren <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg <= RD_LEN;
            rdy       <= 1'b0;
            pt_addr   <= 8'd0;
            i_reg     <= 8'd0;
            j_reg     <= 8'd0;
            k_reg     <= 9'd1;
          end
        end
        RD_LEN:   state_reg <= WAIT_LEN;
        WAIT_LEN: begin
          len_reg   <= pt_rddata;
          ct_addr   <= 8'd0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          state_reg <= WR_LEN;
        end
        WR_LEN: begin
          if (len_reg == 8'd0) begin
            state_reg <= IDLE;
            rdy       <= 1'b1;
          end else begin
            i_reg     <= i_reg + 8'd1;
            s_addr    <= i_reg + 8'd1;
            state_reg <= INC_I;
          end
        end
        INC_I:   state_reg <= WAIT_SI;
        WAIT_SI: begin
          si_reg    <= s_rddata;
          j_reg     <= j_reg + s_rddata;
          s_addr    <= j_reg + s_rddata;
          state_reg <= CALC_J;
        end
        CALC_J:  state_reg <= WAIT_SJ;
        WAIT_SJ: begin
          sj_reg    <= s_rddata;
          s_addr    <= i_reg;
          s_wrdata  <= s_rddata;
          s_wren    <= 1'b1;
          state_reg <= WR_SI;
        end
        WR_SI: begin
          s_addr    <= j_reg;
          s_wrdata  <= si_reg;
          s_wren    <= 1'b1;
          state_reg <= WR_SJ;
        end
        WR_SJ: begin
          // Pad is read after both swap writes have landed in S.
          s_addr    <= si_reg + sj_reg;
          pt_addr   <= k_reg[7:0];
          state_reg <= RD_PAD;
        end
        RD_PAD:   state_reg <= WAIT_PAD;
        WAIT_PAD: begin
          ct_addr   <= k_reg[7:0];
          ct_wrdata <= s_rddata ^ pt_rddata;
          ct_wren   <= 1'b1;
          state_reg <= WR_CT;
        end
        WR_CT: begin
          if (k_reg == {1'b0, len_reg}) begin
            state_reg <= IDLE;
            rdy       <= 1'b1;
          end else begin
            k_reg     <= k_reg + 9'd1;
            i_reg     <= i_reg + 8'd1;
            s_addr    <= i_reg + 8'd1;
            state_reg <= INC_I;
          end
        end
        default: begin
          state_reg <= IDLE;
          rdy       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: a PRGA reference model fills the expected
// ct-write queue, a negedge monitor pops and compares every ct write.
module tb_arc4_encrypt;

  logic       clk = 1'b0;
  logic       rst, en, rdy;
  logic [7:0] s_addr, s_q, s_wrdata, pt_addr, pt_q, ct_addr, ct_wrdata;
  logic       s_wren, ct_wren;

  arc4_encrypt dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_q), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_q),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem[256];
  logic [7:0] ct_mem[256];
  logic [7:0] model_s[256];

  // Memories with registered address; read happens before the write of the same edge.
  always @(posedge clk) begin
    s_q  <= s_mem[s_addr];
    pt_q <= pt_mem[pt_addr];
    if (s_wren)  s_mem[s_addr]   = s_wrdata;
    if (ct_wren) ct_mem[ct_addr] = ct_wrdata;
  end

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [7:0] key_ct[10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] key_pt[10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && ct_wren) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ct_unexpected actual addr=%0d data=%0d required no write", ct_addr, ct_wrdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("ct_addr", int'(ct_addr), int'(e.addr));
        check("ct_data", int'(ct_wrdata), int'(e.data));
      end
    end
  end

  task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key[3];
    logic [7:0] j, t;
    key = '{k0, k1, k2};
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + s_mem[x] + key[x % 3];
      t = s_mem[x]; s_mem[x] = s_mem[j]; s_mem[j] = t;
    end
    for (int x = 0; x < 256; x++) model_s[x] = s_mem[x];
  endtask

  // Reference ARC4 on model_s; optionally queues the expected ct writes.
  task automatic model_run(input int len, input bit push);
    logic [7:0] i, j, t, idx;
    i = 8'd0; j = 8'd0;
    if (push) exp_q.push_back('{8'd0, 8'(len)});
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      j = j + model_s[i];
      t = model_s[i]; model_s[i] = model_s[j]; model_s[j] = t;
      idx = model_s[i] + model_s[j];
      if (push) exp_q.push_back('{8'(k), pt_mem[k] ^ model_s[idx]});
    end
  endtask

  task automatic push_known();
    for (int k = 0; k < 10; k++) exp_q.push_back('{8'(k), key_ct[k]});
  endtask

  task automatic load_known_pt();
    for (int k = 0; k < 10; k++) pt_mem[k] = key_pt[k];
  endtask

  task automatic start();
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    check("rdy_drop", int'(rdy), 0);
  endtask

  task automatic wait_done(input bit pulse, input bit hold, output int cyc, output int swr);
    cyc = 0; swr = 0;
    if (!hold) en = 1'b0;
    while (cyc < 5000) begin
      @(posedge clk); cyc++; #1;
      if (!hold) en = (pulse && cyc < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (s_wren) swr++;
      if (rdy) break;
    end
    if (cyc >= 5000) check("done_timeout", cyc, 0);
  endtask

  task automatic s_compare(string name);
    int n = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== model_s[x]) n++;
    check(name, n, 0);
  endtask

  initial begin
    int cyc, swr, len, n;
    logic [7:0] i, j, t, idx;
    rst = 1'b1; en = 1'b0;
    for (int x = 0; x < 256; x++) begin pt_mem[x] = 8'h00; ct_mem[x] = 8'h00; s_mem[x] = 8'(x); end
    @(posedge clk); @(posedge clk); #1;
    check("rst_rdy", int'(rdy), 1);
    check("rst_s_wren", int'(s_wren), 0);
    check("rst_ct_wren", int'(ct_wren), 0);
    check("rst_addrs", int'(s_addr) + int'(pt_addr) + int'(ct_addr), 0);
    check("rst_data", int'(s_wrdata) + int'(ct_wrdata), 0);
    rst = 1'b0;

    // Known-answer vector with key "Key"
    ksa(8'h4B, 8'h65, 8'h79); load_known_pt(); push_known();
    start(); wait_done(1'b0, 1'b0, cyc, swr);
    check("lat_known", cyc, 84);
    check("swr_known", swr, 18);
    check("q_known", exp_q.size(), 0);
    $display("run known len=9 cycles=%0d", cyc);

    // Zero-length message
    pt_mem[0] = 8'h00; exp_q.push_back('{8'd0, 8'd0});
    start(); wait_done(1'b0, 1'b0, cyc, swr);
    check("lat_len0", cyc, 3);
    check("swr_len0", swr, 0);
    check("q_len0", exp_q.size(), 0);
    $display("run len0 cycles=%0d", cyc);

    // en pulsed while busy must not start a second run
    ksa(8'h4B, 8'h65, 8'h79); load_known_pt(); push_known();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'hEE;
    start(); wait_done(1'b1, 1'b0, cyc, swr);
    check("lat_pulse", cyc, 84);
    repeat (4) @(posedge clk); #1;
    check("rdy_after_pulse", int'(rdy), 1);
    n = 0;
    for (int x = 10; x < 256; x++) if (ct_mem[x] !== 8'hEE) n++;
    check("ct_tail", n, 0);
    check("q_pulse", exp_q.size(), 0);
    $display("run pulsed-en len=9 cycles=%0d", cyc);

    // Reset during WR_SI of byte 3 (fifth S write)
    ksa(8'h4B, 8'h65, 8'h79); load_known_pt(); push_known();
    start(); en = 1'b0; swr = 0; cyc = 0;
    while (swr < 5 && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (s_wren) swr++;
    end
    check("reach_wr_si", swr, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_rdy", int'(rdy), 1);
    check("abort_s_wren", int'(s_wren), 0);
    check("abort_ct_wren", int'(ct_wren), 0);
    rst = 1'b0; exp_q.delete();
    ksa(8'h4B, 8'h65, 8'h79); push_known();
    start(); wait_done(1'b0, 1'b0, cyc, swr);
    check("lat_after_rst", cyc, 84);
    check("q_after_rst", exp_q.size(), 0);
    $display("run after-reset len=9 cycles=%0d", cyc);

    // Full 255-byte message, then decrypt with a freshly keyed S
    pt_mem[0] = 8'd255;
    for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
    ksa(8'h00, 8'h00, 8'h18); model_run(255, 1'b1);
    start(); wait_done(1'b0, 1'b0, cyc, swr);
    check("lat_255", cyc, 2298);
    check("q_255", exp_q.size(), 0);
    check("ct0_255", int'(ct_mem[0]), 255);
    ksa(8'h00, 8'h00, 8'h18);
    i = 8'd0; j = 8'd0; n = 0;
    for (int k = 1; k <= 255; k++) begin
      i = i + 8'd1; j = j + model_s[i];
      t = model_s[i]; model_s[i] = model_s[j]; model_s[j] = t;
      idx = model_s[i] + model_s[j];
      if ((ct_mem[k] ^ model_s[idx]) !== pt_mem[k]) n++;
    end
    check("decrypt_255", n, 0);
    $display("run len=255 cycles=%0d", cyc);

    // Identity S exercises the i==j same-address swap
    for (int x = 0; x < 256; x++) begin s_mem[x] = 8'(x); model_s[x] = 8'(x); end
    pt_mem[0] = 8'd2; pt_mem[1] = 8'd0; pt_mem[2] = 8'd0;
    exp_q.push_back('{8'd0, 8'd2}); exp_q.push_back('{8'd1, 8'd2}); exp_q.push_back('{8'd2, 8'd5});
    model_run(2, 1'b0);
    start(); wait_done(1'b0, 1'b0, cyc, swr);
    check("lat_ident", cyc, 21);
    check("q_ident", exp_q.size(), 0);
    check("ident_s1", int'(s_mem[1]), 1);
    check("ident_s3", int'(s_mem[3]), 2);
    s_compare("ident_s_all");
    $display("run identity len=2 cycles=%0d", cyc);

    // Random keys, two back-to-back runs with en held high across completion
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 30);
      pt_mem[0] = 8'(len);
      for (int x = 1; x <= len; x++) pt_mem[x] = 8'($urandom);
      ksa(8'($urandom), 8'($urandom), 8'($urandom));
      model_run(len, 1'b1); model_run(len, 1'b1);
      start(); wait_done(1'b0, 1'b1, cyc, swr);
      check("lat_rand_a", cyc, 3 + 9 * len);
      @(posedge clk); #1; en = 1'b0;
      check("rdy_restart", int'(rdy), 0);
      wait_done(1'b0, 1'b0, cyc, swr);
      check("lat_rand_b", cyc, 3 + 9 * len);
      check("q_rand", exp_q.size(), 0);
      s_compare("rand_s_all");
      $display("run random r=%0d len=%0d cycles=%0d", r, len, cyc);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
